// File: rtl/sdram_frame_sched.sv
// Row-granular SDRAM write/read scheduler with a two-bank ping-pong frame.
// Ports: clk/rst, FIFO levels, req/grant/done/break per side, row/bank
//   addresses, frame_ready (sticky) and busy.
module sdram_frame_sched #(
  parameter int ROW_W      = 13,
  parameter int LVL_W      = 10,
  parameter int FRAME_ROWS = 300,
  parameter int WR_THRESH  = 256,
  parameter int RD_LOW     = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] wfifo_level,
  input  logic [LVL_W-1:0] rfifo_level,
  output logic             w_req,
  input  logic             w_en,
  input  logic             w_done,
  input  logic             w_break,
  output logic             r_req,
  input  logic             r_en,
  input  logic             r_done,
  input  logic             r_break,
  output logic [ROW_W-1:0] w_row,
  output logic [1:0]       w_bank,
  output logic [ROW_W-1:0] r_row,
  output logic [1:0]       r_bank,
  output logic             frame_ready,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    W_PEND,
    W_BUSY,
    R_PEND,
    R_BUSY
  } state_e;

  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(FRAME_ROWS - 1);
  localparam logic [LVL_W-1:0] WR_TH =
    LVL_W'(WR_THRESH);
  localparam logic [LVL_W-1:0] RD_TH =
    LVL_W'(RD_LOW);

  state_e           state_q, state_d;
  // 1 = last completed transaction was a write
  logic             last_wr_q, last_wr_d;
  logic [ROW_W-1:0] w_row_q, w_row_d;
  logic [ROW_W-1:0] r_row_q, r_row_d;
  logic             w_bank_q, w_bank_d;
  logic             r_bank_q, r_bank_d;
  logic             frame_ready_q, frame_ready_d;
  logic             w_req_q, w_req_d;
  logic             r_req_q, r_req_d;
  logic             busy_q, busy_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    w_row_d       = w_row_q;
    r_row_d       = r_row_q;
    w_bank_d      = w_bank_q;
    r_bank_d      = r_bank_q;
    frame_ready_d = frame_ready_q;

    wr_ok = wfifo_level >= WR_TH;
    rd_ok = frame_ready_q &&
            (rfifo_level <= RD_TH);

    unique case (state_q)
      IDLE: begin
        // tie goes to the side not served last
        if (wr_ok && (!rd_ok || !last_wr_q))
          state_d = W_PEND;
        else if (rd_ok)
          state_d = R_PEND;
      end
      W_PEND: begin
        if (w_en) state_d = W_BUSY;
      end
      R_PEND: begin
        if (r_en) state_d = R_BUSY;
      end
      W_BUSY: begin
        if (w_done) begin
          state_d   = IDLE;
          last_wr_d = 1'b1;
          if (w_row_q == LAST_ROW) begin
            w_row_d       = '0;
            w_bank_d      = ~w_bank_q;
            frame_ready_d = 1'b1;
            // first frame: reader starts on the
            // bank that was just filled
            if (!frame_ready_q)
              r_bank_d = w_bank_q;
          end else begin
            w_row_d = w_row_q + 1'b1;
          end
        end else if (w_break) begin
          state_d = IDLE;
        end
      end
      R_BUSY: begin
        if (r_done) begin
          state_d   = IDLE;
          last_wr_d = 1'b0;
          if (r_row_q == LAST_ROW) begin
            r_row_d = '0;
            // latest complete frame is the bank
            // the writer is not currently using
            r_bank_d = ~w_bank_q;
          end else begin
            r_row_d = r_row_q + 1'b1;
          end
        end else if (r_break) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    w_req_d = (state_d == W_PEND);
    r_req_d = (state_d == R_PEND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_wr_q     <= 1'b0;
      w_row_q       <= '0;
      r_row_q       <= '0;
      w_bank_q      <= 1'b0;
      r_bank_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      w_req_q       <= 1'b0;
      r_req_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_wr_q     <= last_wr_d;
      w_row_q       <= w_row_d;
      r_row_q       <= r_row_d;
      w_bank_q      <= w_bank_d;
      r_bank_q      <= r_bank_d;
      frame_ready_q <= frame_ready_d;
      w_req_q       <= w_req_d;
      r_req_q       <= r_req_d;
      busy_q        <= busy_d;
    end
  end

  assign w_req       = w_req_q;
  assign r_req       = r_req_q;
  assign w_row       = w_row_q;
  assign r_row       = r_row_q;
  assign w_bank      = {1'b0, w_bank_q};
  assign r_bank      = {1'b0, r_bank_q};
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Randomized bench for sdram_frame_sched against a transaction-count model.
// Ports: drives all DUT inputs, checks every output each cycle.
module tb_sdram_frame_sched;

  localparam int FR = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  wfifo_level, rfifo_level;
  logic        w_req, w_en, w_done, w_break;
  logic        r_req, r_en, r_done, r_break;
  logic [12:0] w_row, r_row;
  logic [1:0]  w_bank, r_bank;
  logic        frame_ready, busy;

  sdram_frame_sched dut (
    .clk(clk), .rst(rst),
    .wfifo_level(wfifo_level),
    .rfifo_level(rfifo_level),
    .w_req(w_req), .w_en(w_en),
    .w_done(w_done), .w_break(w_break),
    .r_req(r_req), .r_en(r_en),
    .r_done(r_done), .r_break(r_break),
    .w_row(w_row), .w_bank(w_bank),
    .r_row(r_row), .r_bank(r_bank),
    .frame_ready(frame_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d @%0t",
                  tag, obs, exp, $time);
  endtask

  // Model: rows/banks derive from completed-transaction counts.
  int wcnt, rcnt;
  int pend;   // 0 none, 1 write, 2 read
  int act;    // 0 none, 1 write, 2 read
  bit last_w; // last served was a write
  int rbank;

  task automatic model_step();
    bit wr_ok, rd_ok;
    if (rst) begin
      wcnt = 0; rcnt = 0; pend = 0; act = 0;
      last_w = 0; rbank = 0;
    end else if (pend == 0 && act == 0) begin
      wr_ok = wfifo_level >= 256;
      rd_ok = (wcnt >= FR) && (rfifo_level <= 128);
      if (wr_ok && rd_ok) pend = last_w ? 2 : 1;
      else if (wr_ok)     pend = 1;
      else if (rd_ok)     pend = 2;
    end else if (pend == 1) begin
      if (w_en) begin pend = 0; act = 1; end
    end else if (pend == 2) begin
      if (r_en) begin pend = 0; act = 2; end
    end else if (act == 1) begin
      if (w_done) begin
        wcnt++; last_w = 1; act = 0;
        if (wcnt == FR) rbank = 0;
      end else if (w_break) act = 0;
    end else if (act == 2) begin
      if (r_done) begin
        rcnt++; last_w = 0; act = 0;
        if (rcnt % FR == 0)
          rbank = ((wcnt / FR) - 1) % 2;
      end else if (r_break) act = 0;
    end
  endtask

  task automatic check_all();
    chk("w_req", 32'(w_req), 32'(pend == 1));
    chk("r_req", 32'(r_req), 32'(pend == 2));
    chk("busy", 32'(busy), 32'(pend != 0 || act != 0));
    chk("w_row", 32'(w_row), 32'(wcnt % FR));
    chk("w_bank", 32'(w_bank), 32'((wcnt / FR) % 2));
    chk("frame_ready", 32'(frame_ready), 32'(wcnt >= FR));
    chk("r_row", 32'(r_row), 32'(rcnt % FR));
    chk("r_bank", 32'(r_bank), 32'(rbank));
  endtask

  task automatic pick_inputs(input bit allow_rst);
    int d;
    rst = allow_rst && ($urandom_range(0, 399) == 0);
    wfifo_level = 10'($urandom_range(200, 320));
    rfifo_level = 10'($urandom_range(100, 160));
    if ($urandom % 8 == 0)  wfifo_level = 10'd256;
    if ($urandom % 16 == 0) wfifo_level = 10'd255;
    if ($urandom % 8 == 0)  rfifo_level = 10'd128;
    if ($urandom % 16 == 0) rfifo_level = 10'd129;
    w_en = ($urandom % 3 == 0);
    r_en = ($urandom % 3 == 0);
    d = int'($urandom % 16);
    w_done  = d < 9;
    w_break = d >= 7 && d < 11;
    d = int'($urandom % 16);
    r_done  = d < 9;
    r_break = d >= 7 && d < 11;
  endtask

  int max_wr_frames = 0;
  int max_rd_wraps  = 0;

  initial begin
    rst = 1'b1;
    wfifo_level = '0; rfifo_level = '0;
    w_en = 0; w_done = 0; w_break = 0;
    r_en = 0; r_done = 0; r_break = 0;
    model_step();
    for (int cyc = 0; cyc < 18000; cyc++) begin
      @(negedge clk);
      check_all();
      if (wcnt / FR > max_wr_frames)
        max_wr_frames = wcnt / FR;
      if (rcnt / FR > max_rd_wraps)
        max_rd_wraps = rcnt / FR;
      if (n_chk - n_pass > 40) break;
      pick_inputs(cyc >= 15000);
      model_step();
    end
    chk("wr_frames_seen",
        32'(max_wr_frames >= 2), 32'd1);
    chk("rd_wraps_seen",
        32'(max_rd_wraps >= 1), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
